// File: rtl/tapped_line_buffer_if.sv
// Stream bundle for tapped_line_buffer: sample in, TAPS-wide window out, fill status.
// tap_sum is present only when TAP_SUM_EN is defined.
interface tapped_line_buffer_if #(
  parameter int WIDTH = 8,
  parameter int TAPS  = 3
);
  logic                     input_vld;
  logic [WIDTH-1:0]         din;
  logic [WIDTH*TAPS-1:0]    dout;
  logic                     dout_vld;
  logic                     primed;
`ifdef TAP_SUM_EN
  logic [WIDTH+$clog2(TAPS)-1:0] tap_sum;

  modport master (output input_vld, din, input dout, dout_vld, primed, tap_sum);
  modport slave  (input input_vld, din, output dout, dout_vld, primed, tap_sum);
`else
  modport master (output input_vld, din, input dout, dout_vld, primed);
  modport slave  (input input_vld, din, output dout, dout_vld, primed);
`endif
endinterface

// File: rtl/tapped_line_buffer.sv
// Multi-tap circular delay line (runtime segment length); 1-cycle latency, no backpressure.
// Optional TAP_SUM_EN adds a registered unsigned sum of all taps alongside dout.
module tapped_line_buffer #(
  parameter int WIDTH     = 8,
  parameter int MAX_DEPTH = 28,
  parameter int TAPS      = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [$clog2(MAX_DEPTH+1)-1:0] cfg_len,
  input  logic                           flush,
  tapped_line_buffer_if.slave            bus
);
  localparam int LW   = $clog2(MAX_DEPTH+1);
  localparam int PW   = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam int SEGS = TAPS - 1;
  localparam int FW   = $clog2(SEGS*MAX_DEPTH+1);
  localparam int SW   = WIDTH + $clog2(TAPS);

  logic [LW-1:0]               len_r;
  logic [LW-1:0]               len_clamped;
  logic [PW-1:0]               ptr;
  logic [FW-1:0]               fill;
  logic [FW-1:0]               target;
  logic [SEGS-1:0][WIDTH-1:0]  rd;
  logic                        accept;
  logic                        full;

  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len == '0)
      len_clamped = LW'(1);
    else if (cfg_len > LW'(MAX_DEPTH))
      len_clamped = LW'(MAX_DEPTH);
  end

  assign target = FW'(SEGS * int'(len_r));
  assign accept = bus.input_vld && !flush && !rst;
  assign full   = (fill >= target);

  // Each segment reads its oldest entry and overwrites it with the previous segment's output.
  for (genvar s = 0; s < SEGS; s++) begin : g_seg
    logic [WIDTH-1:0] mem [MAX_DEPTH];
    logic [WIDTH-1:0] seg_in;
    if (s == 0) begin : g_first
      assign seg_in = bus.din;
    end else begin : g_chain
      assign seg_in = rd[s-1];
    end
    assign rd[s] = mem[ptr];
    always_ff @(posedge clk) begin
      if (accept)
        mem[ptr] <= seg_in;
    end
  end

`ifdef TAP_SUM_EN
  logic [SW-1:0] sum_next;
  always_comb begin
    sum_next = SW'(bus.din);
    for (int s = 0; s < SEGS; s++)
      sum_next = sum_next + SW'(rd[s]);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.dout     <= '0;
      bus.dout_vld <= 1'b0;
      bus.primed   <= 1'b0;
      fill         <= '0;
      ptr          <= '0;
      len_r        <= len_clamped;
`ifdef TAP_SUM_EN
      bus.tap_sum  <= '0;
`endif
    end else if (flush) begin
      bus.dout_vld <= 1'b0;
      bus.primed   <= 1'b0;
      fill         <= '0;
      ptr          <= '0;
      len_r        <= len_clamped;
    end else begin
      bus.primed   <= full;
      bus.dout_vld <= bus.input_vld && full;
      if (bus.input_vld) begin
        bus.dout <= {rd, bus.din};
`ifdef TAP_SUM_EN
        bus.tap_sum <= sum_next;
`endif
        if (!full)
          fill <= fill + 1'b1;
        ptr <= (ptr == PW'(len_r - 1'b1)) ? '0 : ptr + 1'b1;
      end
    end
  end
endmodule
